// File: rtl/weighted_arbiter_if.sv
// weighted_arbiter_if
//   Bundles the request/grant handshake of weighted_arbiter.
//   master : requester/consumer side (drives request, weight, lock, grant_accept)
//   slave  : arbiter side (drives grant_valid, grant_oh, grant_index)
// Signals:
//   request      [NUM_ENTRIES]               per-entry access request
//   weight       [NUM_ENTRIES*WEIGHT_WIDTH]  packed credits, entry i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   lock         [NUM_ENTRIES]               per-entry hold-grant request
//   grant_accept                             consumer takes the current grant this cycle
//   grant_valid                              a grant is held
//   grant_oh     [NUM_ENTRIES]               one-hot registered grant, zero when idle
//   grant_index  [$clog2(NUM_ENTRIES)]       binary index of grant_oh
interface weighted_arbiter_if #(
  parameter int NUM_ENTRIES  = 4,
  parameter int WEIGHT_WIDTH = 3
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0]              request;
  logic [NUM_ENTRIES*WEIGHT_WIDTH-1:0] weight;
  logic [NUM_ENTRIES-1:0]              lock;
  logic                                grant_accept;
  logic                                grant_valid;
  logic [NUM_ENTRIES-1:0]              grant_oh;
  logic [IDX_W-1:0]                    grant_index;

  modport master (
    output request, weight, lock, grant_accept,
    input  grant_valid, grant_oh, grant_index
  );

  modport slave (
    input  request, weight, lock, grant_accept,
    output grant_valid, grant_oh, grant_index
  );
endinterface

// File: rtl/weighted_arbiter.sv
// weighted_arbiter
//   Weighted round-robin arbiter. A winner keeps its grant for up to
//   weight[winner] accepted transfers (weight 0 counts as 1), or until it
//   drops its request in an accept cycle. When a grant ends the priority
//   pointer moves past the winner and the next winner is chosen on the same
//   edge, so back-to-back grants have no idle cycle.
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      weighted_arbiter_if.slave (request/weight/lock/grant_accept in,
//            grant_valid/grant_oh/grant_index out)
// Configuration:
//   WEIGHTED_ARBITER_LOCK_EN  when defined, lock[winner]=1 stops a grant from
//                             ending: credit reloads from weight instead.
//                             When undefined, lock is ignored.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no grant held, grant_oh=0, waiting for request
// GRANTED | grant held on idx_q, counting accepted credits
module weighted_arbiter #(
  parameter int NUM_ENTRIES  = 4,
  parameter int WEIGHT_WIDTH = 3
) (
  input logic                clk,
  input logic                reset_n,
  weighted_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_ENTRIES-1:0]  oh_q, oh_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        base_q, base_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  // First set request bit at or above start, wrapping past the top entry.
  function automatic logic [IDX_W-1:0] first_from(
    input logic [NUM_ENTRIES-1:0] req,
    input logic [IDX_W-1:0]       start
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic [IDX_W:0]   sum;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      sum = {1'b0, start} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_ENTRIES)) begin
        sum = sum - (IDX_W+1)'(NUM_ENTRIES);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Credit loaded for a new winner; a zero weight still grants one transfer.
  function automatic logic [WEIGHT_WIDTH-1:0] load_credit(
    input logic [IDX_W-1:0]                    i,
    input logic [NUM_ENTRIES*WEIGHT_WIDTH-1:0] w
  );
    logic [WEIGHT_WIDTH-1:0] c;
    c = w[int'(i)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    return (c == '0) ? WEIGHT_WIDTH'(1) : c;
  endfunction

  function automatic logic [NUM_ENTRIES-1:0] to_oh(input logic [IDX_W-1:0] i);
    logic [NUM_ENTRIES-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh;
  endfunction

  logic                    any_req;
  logic [IDX_W-1:0]        next_base;
  logic [IDX_W-1:0]        win_idle;
  logic [IDX_W-1:0]        win_next;
  logic [WEIGHT_WIDTH-1:0] credit_dec;
  logic                    done_raw;
  logic                    hold;
  logic                    grant_end;

  assign any_req    = |bus.request;
  assign next_base  = (idx_q == IDX_W'(NUM_ENTRIES-1)) ? '0 : idx_q + IDX_W'(1);
  assign win_idle   = first_from(bus.request, base_q);
  // Re-arbitration at grant end already uses the advanced pointer.
  assign win_next   = first_from(bus.request, next_base);
  assign credit_dec = credit_q - WEIGHT_WIDTH'(1);
  // The winner's request is judged in the accept cycle itself.
  assign done_raw   = bus.grant_accept && ((credit_dec == '0) || !bus.request[idx_q]);

`ifdef WEIGHTED_ARBITER_LOCK_EN
  assign hold = done_raw && bus.lock[idx_q];
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign hold        = 1'b0;
`endif

  assign grant_end = done_raw && !hold;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oh_q     <= '0;
      idx_q    <= '0;
      base_q   <= '0;
      credit_q <= '0;
    end else begin
      oh_q     <= oh_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      credit_q <= credit_d;
    end
  end

  // Next-state and next-grant logic
  always_comb begin
    state_d  = state_q;
    oh_d     = oh_q;
    idx_d    = idx_q;
    base_d   = base_q;
    credit_d = credit_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = GRANTED;
          idx_d    = win_idle;
          oh_d     = to_oh(win_idle);
          credit_d = load_credit(win_idle, bus.weight);
        end
      end
      GRANTED: begin
        if (hold) begin
          credit_d = load_credit(idx_q, bus.weight);
        end else if (grant_end) begin
          base_d = next_base;
          if (any_req) begin
            idx_d    = win_next;
            oh_d     = to_oh(win_next);
            credit_d = load_credit(win_next, bus.weight);
          end else begin
            state_d  = IDLE;
            idx_d    = '0;
            oh_d     = '0;
            credit_d = '0;
          end
        end else if (bus.grant_accept) begin
          credit_d = credit_dec;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus.grant_valid = (state_q == GRANTED);
    bus.grant_oh    = oh_q;
    bus.grant_index = idx_q;
  end

endmodule

// File: tb/tb_weighted_arbiter.sv
// tb_weighted_arbiter
//   Scoreboard bench for weighted_arbiter (NUM_ENTRIES=4, WEIGHT_WIDTH=3).
//   The driver applies one input vector per cycle at the falling edge and a
//   behavioural model pushes the grant expected after the next rising edge;
//   a monitor pops and compares just after each rising edge.
module tb_weighted_arbiter;
  localparam int N  = 4;
  localparam int WW = 3;
`ifdef WEIGHTED_ARBITER_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  weighted_arbiter_if #(.NUM_ENTRIES(N), .WEIGHT_WIDTH(WW)) bus();

  weighted_arbiter #(.NUM_ENTRIES(N), .WEIGHT_WIDTH(WW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int idx;
  } exp_t;

  exp_t expq[$];
  int   obs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: owner (-1 = none), remaining credits, priority pointer.
  int m_owner  = -1;
  int m_credit = 0;
  int m_base   = 0;

  int s26[8] = '{0, 1, 2, 3, 0, 0, 0, 0};
  int s27[8] = '{0, 1, 1, 1, 0, 1, 1, 1};
  int s28[8] = '{2, 2, 2, 2, 2, 2, 0, 0};
  int s29[8] = '{1, -1, 2, 0, 0, 0, 0, 0};
  int s31[8] = '{3, 0, 0, 0, 0, 0, 0, 0};
  int s30[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_pick(input logic [N-1:0] req, input int b);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (b + k) % N;
      if (((req >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  function automatic int m_weight(input logic [N*WW-1:0] w, input int i);
    logic [N*WW-1:0] s;
    int v;
    s = (w >> (i * WW)) & (N*WW)'(7);
    v = int'(s);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_step(input logic [N-1:0] req, input logic [N*WW-1:0] w,
                            input logic [N-1:0] lk, input bit acc);
    bit   done;
    exp_t e;
    if (m_owner < 0) begin
      if (req != '0) begin
        m_owner  = m_pick(req, m_base);
        m_credit = m_weight(w, m_owner);
      end
    end else if (acc) begin
      m_credit--;
      done = (m_credit == 0) || (((req >> m_owner) & 4'd1) == 4'd0);
      if (done && LOCK && (((lk >> m_owner) & 4'd1) != 4'd0)) begin
        m_credit = m_weight(w, m_owner);
        done     = 1'b0;
      end
      if (done) begin
        m_base  = (m_owner + 1) % N;
        m_owner = m_pick(req, m_base);
        if (m_owner >= 0) m_credit = m_weight(w, m_owner);
      end
    end
    e.v   = (m_owner >= 0);
    e.idx = m_owner;
    expq.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [N-1:0] req, input logic [N*WW-1:0] w,
                      input logic [N-1:0] lk, input bit acc);
    bus.request      = req;
    bus.weight       = w;
    bus.lock         = lk;
    bus.grant_accept = acc;
    model_step(req, w, lk, acc);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.request      = '0;
    bus.lock         = '0;
    bus.grant_accept = 1'b0;
    reset_n          = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.grant_valid), 32'd0);
    chk("rst_oh", 32'(bus.grant_oh), 32'd0);
    chk("rst_index", 32'(bus.grant_index), 32'd0);
    m_owner  = -1;
    m_credit = 0;
    m_base   = 0;
    #1;
    reset_n = 1'b1;
    step('0, bus.weight, '0, 1'b0);
  endtask

  task automatic check_obs(input string name, input int n, input int e[8]);
    chk({name, "_len"}, 32'(obs.size()), 32'(n));
    for (int i = 0; i < n && i < obs.size(); i++) begin
      chk(name, 32'(obs[i]), 32'(e[i]));
    end
  endtask

  // Monitor
  initial begin : monitor
    exp_t           e;
    logic [N-1:0]   eoh;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        eoh = e.v ? (N'(1) << e.idx) : '0;
        chk("grant_valid", 32'(bus.grant_valid), 32'(e.v));
        chk("grant_oh", 32'(bus.grant_oh), 32'(eoh));
        if (e.v) chk("grant_index", 32'(bus.grant_index), 32'(e.idx));
        obs.push_back(bus.grant_valid ? int'(bus.grant_index) : -1);
      end
    end
  end

  initial begin : driver
    reset_n          = 1'b0;
    bus.request      = '0;
    bus.weight       = '0;
    bus.lock         = '0;
    bus.grant_accept = 1'b0;
    repeat (2) @(negedge clk);
    chk("por_valid", 32'(bus.grant_valid), 32'd0);
    chk("por_oh", 32'(bus.grant_oh), 32'd0);
    chk("por_index", 32'(bus.grant_index), 32'd0);
    reset_n = 1'b1;
    step('0, '0, '0, 1'b0);

    // Equal weights, all requesting, accept every cycle
    do_reset();
    obs.delete();
    repeat (5) step(4'b1111, 12'h249, '0, 1'b1);
    check_obs("seq_rr", 5, s26);

    // Weights {1,3,1,1}, entries 0 and 1 requesting
    do_reset();
    obs.delete();
    repeat (8) step(4'b0011, 12'h259, '0, 1'b1);
    check_obs("seq_weighted", 8, s27);

    // Grant on entry 2 held without accept while its request drops
    do_reset();
    obs.delete();
    step(4'b0100, 12'h249, '0, 1'b0);
    repeat (5) step(4'b0000, 12'h249, '0, 1'b0);
    check_obs("hold_stable", 6, s28);

    // Request dropped in the first accept cycle ends the grant; pointer -> 2
    do_reset();
    obs.delete();
    step(4'b0010, 12'h259, '0, 1'b0);
    step(4'b0000, 12'h259, '0, 1'b1);
    step(4'b0111, 12'h259, '0, 1'b0);
    check_obs("early_end", 3, s29);

    // Reset pulse in the middle of a grant on entry 3
    do_reset();
    step(4'b1000, 12'h249, '0, 1'b0);
    step(4'b1000, 12'h249, '0, 1'b0);
    do_reset();
    obs.delete();
    step(4'b1000, 12'h249, '0, 1'b0);
    check_obs("after_reset", 1, s31);

`ifdef WEIGHTED_ARBITER_LOCK_EN
    do_reset();
    obs.delete();
    step(4'b0011, 12'h249, 4'b0001, 1'b0);
    repeat (6) step(4'b0011, 12'h249, 4'b0001, 1'b1);
    step(4'b0011, 12'h249, 4'b0000, 1'b1);
    check_obs("lock_hold", 8, s30);
`endif

    // Random traffic, including weight changes during grants
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), 12'($urandom), 4'($urandom),
           ($urandom_range(0, 99) < 60));
    end

    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/weighted_arbiter.md
WEIGHTED_ARBITER -- requirements
Module: weighted_arbiter

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4, number of requesters (2..32).
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 3, width of each per-entry credit weight.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port request  input  NUM_ENTRIES  per-entry access request.
REQ-006 SHALL have port weight  input  NUM_ENTRIES*WEIGHT_WIDTH  packed credits; entry i at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-007 SHALL have port lock  input  NUM_ENTRIES  per-entry hold-grant request.
REQ-008 SHALL have port grant_accept  input  1  consumer takes the current grant this cycle.
REQ-009 SHALL have port grant_valid  output  1  a grant is held.
REQ-010 SHALL have port grant_oh  output  NUM_ENTRIES  one-hot registered grant; zero when grant_valid=0.
REQ-011 SHALL have port grant_index  output  $clog2(NUM_ENTRIES)  binary index of grant_oh.

Function
REQ-012 SHALL implement two states: IDLE (grant_valid=0) and GRANTED (grant_valid=1).
REQ-013 SHALL, in IDLE with request!=0, select the first set request bit at or above priority pointer base, wrapping from NUM_ENTRIES-1 to 0, and register it: grant_valid=1 one cycle after request is sampled.
REQ-014 SHALL, on entering GRANTED, load credit counter with the winner's weight; weight 0 treated as 1.
REQ-015 SHALL hold grant_oh, grant_index and grant_valid stable in GRANTED until grant_accept, regardless of request changes.
REQ-016 SHALL, on grant_accept in GRANTED, decrement credit; grant ends when credit reaches 0 or winner's request is 0 in the accept cycle.
REQ-017 SHALL, when grant ends, set base to winner index+1 (mod NUM_ENTRIES) and in the same edge re-arbitrate using the new base and current request: no bubble cycle between back-to-back grants.
REQ-018 SHALL, if grant ends with request==0, enter IDLE with grant_oh=0.
REQ-019 SHALL let a sole requester win again immediately after its grant ends (reload full credit).
REQ-020 SHALL ignore weight changes for an in-progress grant; weight is sampled only at grant load.
REQ-021 SHALL leave base unchanged while no grant ends.

Reset
REQ-022 SHALL, on reset_n low, asynchronously force IDLE, grant_valid=0, grant_oh=0, grant_index=0, credit=0, base=0.
REQ-023 SHALL, on reset mid-grant, drop the grant immediately; first grant after release follows REQ-013 from base 0.

Configuration
REQ-024 SHALL, with macro WEIGHTED_ARBITER_LOCK_EN defined, suppress grant end while lock[winner]=1: credit reloads from weight instead of ending; base unchanged.
REQ-025 SHALL, without WEIGHTED_ARBITER_LOCK_EN, keep the lock port present but ignore it entirely.

Verification
REQ-026 SHALL cover: N=4, all weights 1, request=4'b1111, grant_accept=1 every cycle -> grant_index sequence 0,1,2,3,0 with no gaps.
REQ-027 SHALL cover: weights {1,3,1,1}, request=4'b0011, accept every cycle -> grants 0,1,1,1,0,1,1,1.
REQ-028 SHALL cover: grant on entry 2, grant_accept held 0 for 5 cycles while request[2] drops -> grant_oh=4'b0100 stable all 5 cycles.
REQ-029 SHALL cover: weight[1]=3, request=4'b0010 deasserted in the accept cycle after first accept -> grant ends after 1 accept; base=2.
REQ-030 SHALL cover: with LOCK_EN, lock[0]=1, weight[0]=1, request=4'b0011, 6 accepts -> entry 0 granted all 6; lock[0]=0 -> next grant entry 1.
REQ-031 SHALL cover: reset_n pulsed low mid-grant on entry 3 -> grant_valid=0 within same cycle; after release with request=4'b1000, grant_index=3 one cycle later.
